id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: combinational decode of the fetched word, operand forwarding,
// load-use bubble insertion and a registered hand-off to execute.
module id_stage #(
  parameter int XLEN     = 32,
  parameter int FWD_N    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  inst_valid_in,
  input  logic [31:0]           inst_in,
  input  logic [XLEN-1:0]       inst_addr_in,
  output logic                  inst_ready_out,
  output logic [4:0]            reg1_raddr_out,
  output logic [4:0]            reg2_raddr_out,
  output logic                  reg1_renable_out,
  output logic                  reg2_renable_out,
  input  logic [XLEN-1:0]       rdata1_in,
  input  logic [XLEN-1:0]       rdata2_in,
  input  logic [FWD_N-1:0]      fwd_we_in,
  input  logic [5*FWD_N-1:0]    fwd_waddr_in,
  input  logic [XLEN*FWD_N-1:0] fwd_wdata_in,
  input  logic                  flush_in,
  input  logic                  ex_ready_in,
  output logic                  ex_valid_out,
  output logic [31:0]           inst_out,
  output logic [XLEN-1:0]       inst_addr_out,
  output logic [XLEN-1:0]       op1_out,
  output logic [XLEN-1:0]       op2_out,
  output logic                  reg_we_out,
  output logic [4:0]            reg_waddr_out,
  output logic                  is_load_out,
  output logic                  illegal_out,
  output logic                  stall_out
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  typedef enum logic {RUN, BUBBLE} state_e;

  // Lowest-index forwarding hit wins; x0 always reads as zero.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [4:0]            addr,
    input logic [XLEN-1:0]       rdata,
    input logic [FWD_N-1:0]      we,
    input logic [5*FWD_N-1:0]    waddr,
    input logic [XLEN*FWD_N-1:0] wdata
  );
    logic [XLEN-1:0] val;
    val = rdata;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (we[i] && (waddr[5*i +: 5] == addr)) val = wdata[XLEN*i +: XLEN];
    end
    if (addr == 5'd0) val = '0;
    return val;
  endfunction

  state_e          state_q;
  logic [1:0]      bub_cnt_q;
  logic            ex_valid_q, we_q, load_q, illegal_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] addr_q, op1_q, op2_q;
  logic [4:0]      waddr_q;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_u, src1, src2;
  logic            rs1_en, rs2_en, we_d, load_d, illegal_d, hazard;
  logic [31:0]     inst_d;
  logic [XLEN-1:0] op1_d, op2_d;
  logic [4:0]      waddr_d;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign imm_i  = {{(XLEN-12){inst_in[31]}}, inst_in[31:20]};
  assign imm_u  = {{(XLEN-20){inst_in[31]}}, inst_in[31:12]} << 12;
  assign src1   = pick_operand(rs1, rdata1_in, fwd_we_in, fwd_waddr_in, fwd_wdata_in);
  assign src2   = pick_operand(rs2, rdata2_in, fwd_we_in, fwd_waddr_in, fwd_wdata_in);

  always_comb begin
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    we_d      = 1'b1;
    load_d    = 1'b0;
    illegal_d = 1'b0;
    inst_d    = inst_in;
    op1_d     = '0;
    op2_d     = '0;
    case (opcode)
      OP_IMM:   begin rs1_en = 1'b1; op1_d = src1; op2_d = imm_i; end
      OP_REG:   begin rs1_en = 1'b1; rs2_en = 1'b1; op1_d = src1; op2_d = src2; end
      OP_LUI:   op1_d = imm_u;
      OP_AUIPC: begin op1_d = inst_addr_in; op2_d = imm_u; end
      OP_STORE, OP_BRANCH: begin
        rs1_en = 1'b1; rs2_en = 1'b1; op1_d = src1; op2_d = src2; we_d = 1'b0;
      end
      OP_LOAD:  begin rs1_en = 1'b1; op1_d = src1; load_d = 1'b1; end
      OP_JAL:   ;
      OP_JALR:  begin rs1_en = 1'b1; op1_d = src1; end
      default:  begin inst_d = NOP; we_d = 1'b0; illegal_d = 1'b1; end
    endcase
  end

  assign waddr_d = we_d ? rd : 5'd0;

  assign reg1_raddr_out   = rs1;
  assign reg2_raddr_out   = rs2;
  assign reg1_renable_out = rst_n_in & inst_valid_in & rs1_en;
  assign reg2_renable_out = rst_n_in & inst_valid_in & rs2_en;

  assign hazard = ex_valid_q && load_q && (waddr_q != 5'd0) &&
                  ((reg1_renable_out && (waddr_q == rs1)) ||
                   (reg2_renable_out && (waddr_q == rs2)));

  assign inst_ready_out = rst_n_in && (state_q == RUN) && inst_valid_in && !hazard &&
                          (ex_ready_in || !ex_valid_q) && !flush_in;
  assign stall_out      = rst_n_in && inst_valid_in && !inst_ready_out && !flush_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= RUN;
      bub_cnt_q  <= 2'd0;
      ex_valid_q <= 1'b0;
      inst_q     <= NOP;
      addr_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= 5'd0;
      load_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (flush_in) begin
        ex_valid_q <= 1'b0;
        state_q    <= RUN;
        bub_cnt_q  <= 2'd0;
      end else if (state_q == BUBBLE) begin
        ex_valid_q <= 1'b0;
        bub_cnt_q  <= bub_cnt_q - 2'd1;
        if (bub_cnt_q == 2'd1) state_q <= RUN;
      end else if (inst_ready_out) begin
        ex_valid_q <= 1'b1;
        inst_q     <= inst_d;
        addr_q     <= inst_addr_in;
        op1_q      <= op1_d;
        op2_q      <= op2_d;
        we_q       <= we_d;
        waddr_q    <= waddr_d;
        load_q     <= load_d;
        illegal_q  <= illegal_d;
      end else if (ex_ready_in || !ex_valid_q) begin
        // Execute drained the register: either nothing to issue or a load-use bubble.
        ex_valid_q <= 1'b0;
        if (hazard) begin
          bub_cnt_q <= 2'(LOAD_LAT - 1);
          state_q   <= (LOAD_LAT > 1) ? BUBBLE : RUN;
        end
      end
    end
  end

  assign ex_valid_out  = ex_valid_q;
  assign inst_out      = inst_q;
  assign inst_addr_out = addr_q;
  assign op1_out       = op1_q;
  assign op2_out       = op2_q;
  assign reg_we_out    = we_q;
  assign reg_waddr_out = waddr_q;
  assign is_load_out   = load_q;
  assign illegal_out   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written hazard,
// stall and flush sequences, then random traffic against a reference model.
module tb_id_stage;
  localparam int XLEN = 32, FWD_N = 2, LOAD_LAT = 2;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [31:0] LW5    = 32'h0001_2283;   // lw   x5,0(x2)
  localparam logic [31:0] ADD6   = 32'h0002_8333;   // add  x6,x5,x0
  localparam logic [31:0] ADDI1  = 32'h0050_0093;   // addi x1,x0,5

  logic              clk = 1'b0;
  logic              rst_n, inst_valid, flush, ex_ready;
  logic [31:0]       inst, inst_addr, rdata1, rdata2;
  logic [1:0]        fwd_we;
  logic [9:0]        fwd_waddr;
  logic [63:0]       fwd_wdata;
  logic              inst_ready, ren1, ren2, ex_valid, reg_we, is_load, illegal, stall;
  logic [4:0]        raddr1, raddr2, reg_waddr;
  logic [31:0]       inst_o, addr_o, op1, op2;

  id_stage #(.XLEN(XLEN), .FWD_N(FWD_N), .LOAD_LAT(LOAD_LAT)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .inst_valid_in(inst_valid), .inst_in(inst),
    .inst_addr_in(inst_addr), .inst_ready_out(inst_ready),
    .reg1_raddr_out(raddr1), .reg2_raddr_out(raddr2),
    .reg1_renable_out(ren1), .reg2_renable_out(ren2),
    .rdata1_in(rdata1), .rdata2_in(rdata2),
    .fwd_we_in(fwd_we), .fwd_waddr_in(fwd_waddr), .fwd_wdata_in(fwd_wdata),
    .flush_in(flush), .ex_ready_in(ex_ready), .ex_valid_out(ex_valid),
    .inst_out(inst_o), .inst_addr_out(addr_o), .op1_out(op1), .op2_out(op2),
    .reg_we_out(reg_we), .reg_waddr_out(reg_waddr), .is_load_out(is_load),
    .illegal_out(illegal), .stall_out(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, op1, op2;
    logic        we;
    logic [4:0]  wa;
    logic        ld, ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst, addr, r1, r2;
    logic [1:0]  fwe;
    logic [9:0]  fwa;
    logic [63:0] fwd;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input exp_t e);
    chk({tag, ".inst"},  64'(inst_o),    64'(e.inst));
    chk({tag, ".op1"},   64'(op1),       64'(e.op1));
    chk({tag, ".op2"},   64'(op2),       64'(e.op2));
    chk({tag, ".we"},    64'(reg_we),    64'(e.we));
    chk({tag, ".waddr"}, 64'(reg_waddr), 64'(e.wa));
    chk({tag, ".load"},  64'(is_load),   64'(e.ld));
    chk({tag, ".ill"},   64'(illegal),   64'(e.ill));
  endtask

  task automatic apply(input vec_t v);
    inst = v.inst; inst_addr = v.addr; rdata1 = v.r1; rdata2 = v.r2;
    fwd_we = v.fwe; fwd_waddr = v.fwa; fwd_wdata = v.fwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: operand value as seen by the decoder for one source register.
  function automatic logic [31:0] ref_src(input logic [4:0] ad, input logic [31:0] rd,
                                          input logic [1:0] fwe, input logic [9:0] fwa,
                                          input logic [63:0] fwd);
    if (ad == 5'd0) return 32'd0;
    for (int i = 0; i < 2; i++)
      if (fwe[i] && fwa[i*5 +: 5] == ad) return fwd[i*32 +: 32];
    return rd;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [1:0] fwe, input logic [9:0] fwa,
                                      input logic [63:0] fwd);
    exp_t e;
    logic [31:0] a, b, immi, immu;
    a    = ref_src(w[19:15], r1, fwe, fwa, fwd);
    b    = ref_src(w[24:20], r2, fwe, fwa, fwd);
    immi = 32'($signed(w[31:20]));
    immu = {w[31:12], 12'h000};
    e = '{inst: w, op1: 32'd0, op2: 32'd0, we: 1'b1, wa: w[11:7], ld: 1'b0, ill: 1'b0};
    case (w[6:0])
      7'h13: begin e.op1 = a; e.op2 = immi; end
      7'h33: begin e.op1 = a; e.op2 = b; end
      7'h37: e.op1 = immu;
      7'h17: begin e.op1 = pc; e.op2 = immu; end
      7'h23, 7'h63: begin e.op1 = a; e.op2 = b; e.we = 1'b0; e.wa = 5'd0; end
      7'h03: begin e.op1 = a; e.ld = 1'b1; end
      7'h6F: ;
      7'h67: e.op1 = a;
      default: begin e.inst = NOP_W; e.we = 1'b0; e.wa = 5'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles, stalls;
    bit found, mv, mill;
    exp_t me, e;
    logic [31:0] r;
    logic [6:0] ops[9];

    vt[0]  = '{32'h0050_0093, 32'h0, 32'hDEAD, 32'h0, 2'b00, 10'h000, 64'h0,
               '{32'h0050_0093, 32'h0, 32'h5, 1'b1, 5'd1, 1'b0, 1'b0}};
    vt[1]  = '{32'h0010_8133, 32'h4, 32'h111, 32'h222, 2'b01, 10'h001, 64'h5,
               '{32'h0010_8133, 32'h5, 32'h5, 1'b1, 5'd2, 1'b0, 1'b0}};
    vt[2]  = '{32'h0001_8233, 32'h8, 32'h777, 32'h888, 2'b11, 10'h063, 64'h0000000B_0000000A,
               '{32'h0001_8233, 32'hA, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0}};
    vt[3]  = '{32'h0000_007F, 32'hC, 32'h1, 32'h2, 2'b00, 10'h000, 64'h0,
               '{NOP_W, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1}};
    vt[4]  = '{32'hFFFF_F3B7, 32'h10, 32'h1, 32'h2, 2'b00, 10'h000, 64'h0,
               '{32'hFFFF_F3B7, 32'hFFFF_F000, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0}};
    vt[5]  = '{32'h1234_5417, 32'h1000, 32'h1, 32'h2, 2'b00, 10'h000, 64'h0,
               '{32'h1234_5417, 32'h1000, 32'h1234_5000, 1'b1, 5'd8, 1'b0, 1'b0}};
    vt[6]  = '{32'hFFF5_0493, 32'h18, 32'h20, 32'h2, 2'b00, 10'h000, 64'h0,
               '{32'hFFF5_0493, 32'h20, 32'hFFFF_FFFF, 1'b1, 5'd9, 1'b0, 1'b0}};
    vt[7]  = '{32'h00B6_2023, 32'h1C, 32'h100, 32'h200, 2'b11, 10'h185, 64'h00000055_00000066,
               '{32'h00B6_2023, 32'h55, 32'h200, 1'b0, 5'd0, 1'b0, 1'b0}};
    vt[8]  = '{32'h0020_8063, 32'h20, 32'h3, 32'h4, 2'b00, 10'h000, 64'h0,
               '{32'h0020_8063, 32'h3, 32'h4, 1'b0, 5'd0, 1'b0, 1'b0}};
    vt[9]  = '{LW5, 32'h24, 32'h30, 32'h4, 2'b00, 10'h000, 64'h0,
               '{LW5, 32'h30, 32'h0, 1'b1, 5'd5, 1'b1, 1'b0}};
    vt[10] = '{32'h0080_00EF, 32'h28, 32'hAAA, 32'hBBB, 2'b00, 10'h000, 64'h0,
               '{32'h0080_00EF, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0}};
    vt[11] = '{32'h0002_80E7, 32'h2C, 32'h40, 32'h4, 2'b00, 10'h000, 64'h0,
               '{32'h0002_80E7, 32'h40, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0}};

    // Reset with a valid instruction offered
    rst_n = 1'b0; inst_valid = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    apply(vt[1]);
    @(negedge clk);
    chk("rst.ready", 64'(inst_ready), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.ren1",  64'(ren1), 64'd0);
    chk("rst.ren2",  64'(ren2), 64'd0);
    tick();
    chk("rst.valid", 64'(ex_valid), 64'd0);
    check_regs("rst", '{NOP_W, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Directed vector table, one instruction per cycle
    foreach (vt[i]) begin
      apply(vt[i]);
      inst_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d.ready", i), 64'(inst_ready), 64'd1);
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(ex_valid), 64'd1);
      check_regs($sformatf("vec%0d", i), vt[i].e);
      $display("vec %0d inst=%h op1=%h op2=%h", i, inst_o, op1, op2);
    end
    inst_valid = 1'b0; fwd_we = 2'b00;
    tick();

    // Load-use: LW x5 then ADD x6,x5,x0 -> LOAD_LAT bubbles
    inst = LW5; rdata1 = 32'h30; inst_valid = 1'b1;
    tick();
    inst = ADD6; rdata1 = 32'h99; rdata2 = 32'h5;
    bubbles = 0; stalls = 0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (stall) stalls++;
      tick();
      if (ex_valid && inst_o == ADD6) found = 1'b1;
      else if (!ex_valid) bubbles++;
    end
    chk("lu.issued",  64'(found), 64'd1);
    chk("lu.bubbles", 64'(bubbles), 64'(LOAD_LAT));
    chk("lu.stalls",  64'(stalls), 64'(LOAD_LAT));
    check_regs("lu.add", '{ADD6, 32'h99, 32'h0, 1'b1, 5'd6, 1'b0, 1'b0});
    $display("loaduse bubbles=%0d stalls=%0d", bubbles, stalls);

    // Back-pressure: output held for 3 cycles
    ex_ready = 1'b0; inst = ADDI1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.ready", 64'(inst_ready), 64'd0);
      chk("bp.stall", 64'(stall), 64'd1);
      tick();
      chk("bp.valid", 64'(ex_valid), 64'd1);
      check_regs("bp.hold", '{ADD6, 32'h99, 32'h0, 1'b1, 5'd6, 1'b0, 1'b0});
    end
    ex_ready = 1'b1;
    #1;
    chk("bp.release", 64'(inst_ready), 64'd1);
    tick();
    check_regs("bp.next", '{ADDI1, 32'h0, 32'h5, 1'b1, 5'd1, 1'b0, 1'b0});
    $display("backpressure done inst=%h", inst_o);

    // Flush during BUBBLE, then the waiting ADD is accepted at once
    inst = LW5; rdata1 = 32'h30;
    tick();
    inst = ADD6; rdata1 = 32'h99;
    tick();
    chk("fb.bubble", 64'(ex_valid), 64'd0);
    flush = 1'b1;
    #1;
    chk("fb.ready", 64'(inst_ready), 64'd0);
    chk("fb.stall", 64'(stall), 64'd0);
    tick();
    flush = 1'b0;
    chk("fb.valid", 64'(ex_valid), 64'd0);
    #1;
    chk("fb.accept", 64'(inst_ready), 64'd1);
    tick();
    chk("fb.issued", 64'(ex_valid), 64'd1);
    chk("fb.inst", 64'(inst_o), 64'(ADD6));
    $display("flush-in-bubble done inst=%h", inst_o);

    // Flush kills a valid output
    inst_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fo.valid", 64'(ex_valid), 64'd0);

    // Reset in BUBBLE abandons the sequence
    inst_valid = 1'b1; inst = LW5;
    tick();
    inst = ADD6;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rb.valid", 64'(ex_valid), 64'd0);
    chk("rb.inst", 64'(inst_o), 64'(NOP_W));
    #1;
    chk("rb.accept", 64'(inst_ready), 64'd1);
    tick();
    chk("rb.issued", 64'(inst_o), 64'(ADD6));
    $display("reset-in-bubble done inst=%h", inst_o);

    // Random traffic (no loads) against the reference model
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0B};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mv = 1'b0; mill = 1'b0; me = '{NOP_W, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      inst = {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:7],
              ops[$urandom_range(0, 8)]};
      inst_addr = $urandom(); rdata1 = $urandom(); rdata2 = $urandom();
      fwd_we = 2'($urandom_range(0, 3));
      fwd_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_wdata = {32'($urandom()), 32'($urandom())};
      inst_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd.ready", 64'(inst_ready), 64'(inst_valid && (ex_ready || !mv)));
      chk("rnd.stall", 64'(stall), 64'(inst_valid && !(ex_ready || !mv)));
      e = ref_decode(inst, inst_addr, rdata1, rdata2, fwd_we, fwd_waddr, fwd_wdata);
      if (mv && !ex_ready) begin
        mill = 1'b0;
      end else if (inst_valid) begin
        mv = 1'b1; me = e; mill = e.ill;
      end else begin
        mv = 1'b0; mill = 1'b0;
      end
      tick();
      chk("rnd.valid", 64'(ex_valid), 64'(mv));
      chk("rnd.ill", 64'(illegal), 64'(mill));
      if (mv) begin
        me.ill = mill;
        check_regs("rnd", me);
      end
      $display("rnd %0d in=%h valid=%0d out=%h op1=%h op2=%h", n, inst, ex_valid, inst_o, op1, op2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
